// File: rtl/counter_req_arb.sv
// Round-robin inc/dec request arbiter that sits in front of one shared counter.
// It rejects requests that would wrap the counter, judged on the projected count.
module counter_req_arb #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rej,
  input  logic [CW-1:0]   cnt,
  output logic            inc,
  output logic            dec
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;

  logic [CW:0]   proj;
  logic          full;
  logic          empty;
  logic          found;
  logic [PW-1:0] cand;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // count the counter will hold once last cycle's strobe lands
  assign proj  = {1'b0, cnt}
               + {{CW{1'b0}}, inc_q}
               - {{CW{1'b0}}, dec_q};
  assign full  = (proj == {1'b0, {CW{1'b1}}});
  assign empty = (proj == '0);

  assign inc = inc_q;
  assign dec = dec_q;

  // first requester after the last served one, wrapping around
  always_comb begin
    found = 1'b0;
    cand  = ptr_q;
    sum   = '0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  // grant or reject the candidate and prepare the next strobe
  always_comb begin
    gnt   = '0;
    rej   = '0;
    inc_d = 1'b0;
    dec_d = 1'b0;
    ptr_d = ptr_q;
    if (!rst && found) begin
      ptr_d = cand;
      unique case (1'b1)
        (op[cand] && full):   rej[cand] = 1'b1;
        (op[cand] && !full): begin
          gnt[cand] = 1'b1;
          inc_d     = 1'b1;
        end
        (!op[cand] && empty): rej[cand] = 1'b1;
        default: begin
          gnt[cand] = 1'b1;
          dec_d     = 1'b1;
        end
      endcase
    end
  end

  // pointer and strobe registers; reset leaves index 0 first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PW'(NREQ-1);
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      inc_q <= inc_d;
      dec_q <= dec_d;
    end
  end

endmodule

// File: tb/tb_counter_req_arb.sv
// Directed bench for counter_req_arb with a behavioural counter
// closing the cnt feedback loop.
module tb_counter_req_arb;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] op;
  logic [3:0] gnt;
  logic [3:0] rej;
  logic [7:0] cnt_m;
  logic       inc;
  logic       dec;
  logic       ld;
  logic [7:0] ld_val;

  int n_run;
  int n_fail;

  counter_req_arb #(.NREQ(4), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .op  (op),
    .gnt (gnt),
    .rej (rej),
    .cnt (cnt_m),
    .inc (inc),
    .dec (dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared counter model, with a preload hook for boundary tests
  always @(posedge clk) begin
    if (rst)
      cnt_m <= 8'd0;
    else if (ld)
      cnt_m <= ld_val;
    else if (inc)
      cnt_m <= cnt_m + 8'd1;
    else if (dec)
      cnt_m <= cnt_m - 8'd1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic obs(input string tag,
                     input logic [3:0] g,
                     input logic [3:0] r,
                     input logic       i,
                     input logic       d,
                     input logic [7:0] c);
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".rej"}, 32'(rej), 32'(r));
    check({tag, ".inc"}, 32'(inc), 32'(i));
    check({tag, ".dec"}, 32'(dec), 32'(d));
    check({tag, ".cnt"}, 32'(cnt_m), 32'(c));
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    req    = 4'b1111;
    op     = 4'b1111;
    ld     = 1'b0;
    ld_val = 8'd0;
    @(negedge clk);

    // reset held three cycles with everyone asking
    obs("rst0", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0);
    step();
    obs("rst1", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0);
    step();
    obs("rst2", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0);
    step();
    rst = 1'b0;

    // round-robin increments from zero
    obs("rr0", 4'b0001, 4'b0000, 1'b0, 1'b0, 8'd0);
    step();
    obs("rr1", 4'b0010, 4'b0000, 1'b1, 1'b0, 8'd0);
    step();
    obs("rr2", 4'b0100, 4'b0000, 1'b1, 1'b0, 8'd1);
    step();
    obs("rr3", 4'b1000, 4'b0000, 1'b1, 1'b0, 8'd2);
    step();
    obs("rr4", 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd3);
    step();
    obs("rr5", 4'b0010, 4'b0000, 1'b1, 1'b0, 8'd4);
    step();
    req = 4'b0000;
    obs("rr6", 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd5);
    step();
    obs("rr7", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd6);
    ld     = 1'b1;
    ld_val = 8'd254;
    step();
    ld = 1'b0;

    // saturation: ptr=1, so req0 wins, then req1 sees proj=255
    req = 4'b0011;
    op  = 4'b0011;
    obs("sat0", 4'b0001, 4'b0000, 1'b0, 1'b0, 8'd254);
    step();
    req = 4'b0010;
    obs("sat1", 4'b0000, 4'b0010, 1'b1, 1'b0, 8'd254);
    step();
    obs("sat2", 4'b0000, 4'b0010, 1'b0, 1'b0, 8'd255);
    step();
    req = 4'b0001;
    op  = 4'b0000;
    obs("sat3", 4'b0001, 4'b0000, 1'b0, 1'b0, 8'd255);
    step();
    req = 4'b0000;
    obs("sat4", 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd255);
    ld     = 1'b1;
    ld_val = 8'd0;
    step();
    ld = 1'b0;
    obs("sat5", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0);

    // underflow reject moves ptr to 2, so index 3 beats index 1
    req = 4'b0100;
    op  = 4'b0000;
    obs("und0", 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd0);
    step();
    req = 4'b1010;
    op  = 4'b1010;
    obs("und1", 4'b1000, 4'b0000, 1'b0, 1'b0, 8'd0);
    step();
    req = 4'b0000;
    obs("und2", 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0);
    step();
    ld     = 1'b1;
    ld_val = 8'd10;
    step();
    ld = 1'b0;

    // mixed: req1 increments, req3 decrements
    req = 4'b1010;
    op  = 4'b0010;
    obs("mix0", 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd10);
    step();
    obs("mix1", 4'b1000, 4'b0000, 1'b1, 1'b0, 8'd10);
    step();
    obs("mix2", 4'b0010, 4'b0000, 1'b0, 1'b1, 8'd11);
    step();
    obs("mix3", 4'b1000, 4'b0000, 1'b1, 1'b0, 8'd10);
    step();
    req = 4'b0000;
    obs("mix4", 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd11);
    step();
    obs("mix5", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd10);

    // reset lands while an increment strobe is in flight
    req = 4'b0010;
    op  = 4'b0010;
    obs("mr0", 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd10);
    step();
    rst = 1'b1;
    req = 4'b1111;
    op  = 4'b1111;
    obs("mr1", 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd10);
    step();
    obs("mr2", 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0);
    step();
    rst = 1'b0;
    obs("mr3", 4'b0001, 4'b0000, 1'b0, 1'b0, 8'd0);
    step();
    obs("mr4", 4'b0010, 4'b0000, 1'b1, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_req_arb.md
# counter_req_arb

Round-robin request arbiter and sequencer that shares a single `counter_inc_dec` instance between `NREQ` requesters. Each requester asks for one increment or one decrement. The block grants one request per cycle and drives the counter's `inc`/`dec` strobes. It rejects any request that would overflow or underflow the counter, using a projected count that accounts for the command already in flight. It sits directly in front of the counter, with `cnt` fed back from the counter output.

## Interface
- `NREQ`, default 4: number of requesters (2..16).
- `CW`, default 8: counter width. Must match the counter instance.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NREQ`: per-requester request. Held high until `gnt` or `rej` is seen.
- `op` in `NREQ`: per-requester operation, 1 = increment, 0 = decrement. Stable while the matching `req` is high.
- `gnt` out `NREQ`: one-hot (or zero) accept pulse, combinational in the decision cycle.
- `rej` out `NREQ`: one-hot (or zero) reject pulse, combinational in the decision cycle.
- `cnt` in `CW`: current counter value, fed back from the counter.
- `inc` out 1: increment strobe to the counter (registered).
- `dec` out 1: decrement strobe to the counter (registered).

## Operation
- Only one requester is served per cycle, and it receives exactly one of `gnt` or `rej`.
- Selection is round-robin.
  - `ptr` holds the index of the last served requester.
  - The search starts at `ptr+1` and wraps modulo `NREQ`.
  - The first index with `req` high is the candidate.
- Projected count is `proj = cnt + inc - dec`, computed at `CW+1` bits. It reflects the strobe issued last cycle that the counter has not yet absorbed.
- For an increment candidate: if `proj == 2^CW-1`, assert `rej`; otherwise assert `gnt` and set `inc` for the next cycle.
- For a decrement candidate: if `proj == 0`, assert `rej`; otherwise assert `gnt` and set `dec` for the next cycle.
- `ptr` updates to the candidate index on either `gnt` or `rej`. With no candidate, `ptr` holds.
- `inc` and `dec` are never high together. Each is a single-cycle pulse per grant. Back-to-back grants give `inc`/`dec` high on consecutive cycles.
- If there is no candidate, `inc` and `dec` are 0 in the next cycle.
- A requester that drops `req` before being served is simply skipped. No state is kept for it.

## Timing
- Reset (`rst` high at an edge):
  - `inc`=0, `dec`=0, `ptr`=`NREQ-1`, so index 0 has first priority.
  - While `rst` is high, `gnt`=0 and `rej`=0 regardless of `req`.
  - The counter is reset at the same time (to 0) by the integration.
- Decision cycle t: `req`, `op`, `cnt`, `inc` and `dec` are sampled, and `gnt`/`rej` are valid combinationally in t.
- The requester sees `gnt`/`rej` at the end-of-t edge and must deassert or change `req` from t+1.
- Strobe timing: `inc`/`dec` are high during t+1, and the counter updates `cnt` at the end-of-t+1 edge.
- Throughput is one command per cycle, and there are no idle bubbles between grants.
- Boundary cases:
  - At `proj == 2^CW-1`, increments are rejected every cycle while decrements are still granted.
  - At `proj == 0`, decrements are rejected while increments are granted.
  - The projection prevents a double grant across the in-flight cycle.
- Reset mid-operation: if `rst` is high in a cycle where `inc` is high, `inc` is 0 in the following cycle. No pending command is retained.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `req`=4'b1111 and `op`=4'b1111.
  - Required: `gnt`=0, `rej`=0, `inc`=`dec`=0 throughout.
  - Required: the first cycle after release gives `gnt`=4'b0001.
- **Round-robin increments:** `req`=4'b1111, `op`=4'b1111, each requester re-asserting `req` right after its grant, starting at `cnt`=0.
  - Required: `gnt` sequence 0001, 0010, 0100, 1000, 0001.
  - Required: `inc` high every cycle from the second grant cycle, `cnt`=4 one cycle after the 4th `inc` pulse.
- **Saturation:** `cnt`=254, `req0` and `req1` both requesting increments from the same cycle.
  - Required: `gnt[0]` first.
  - Required: next cycle `proj`=255, so `rej[1]`, with no `inc` that cycle; `cnt` stays at 255.
- **Underflow:** `cnt`=0 with no strobe in flight, `req2` requesting a decrement.
  - Required: `rej`=4'b0100, `dec` stays 0, `ptr`=2, so the next candidate search starts at index 3.
- **Mixed operations:** `cnt`=10, `req1` increment and `req3` decrement continuously.
  - Required: grants alternate 1, 3, 1, 3.
  - Required: `inc` and `dec` alternate and are never high together, and `cnt` oscillates between 10 and 11.
- **Mid-operation reset:** assert `rst` in the cycle where `inc`=1.
  - Required: `inc`=0 next cycle, `gnt`/`rej`=0 while `rst` is high, and after release `gnt` goes to index 0 first.
